cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Shares the ROB writeback lanes among the functional-unit result producers. Each cycle it grants up to NUM_LANES pending results in round-robin order and registers them onto the common data bus that feeds the ROB (`cdb_i`) and the reservation stations. On a ROB misprediction it suppresses grants and clears the bus so no stale writeback reaches the flushed ROB.

## Interface
- NUM_REQ, default 6: number of result producers (FU output ports).
- NUM_LANES, default NUM_FU: CDB lanes; matches the ROB `cdb_i` array size.
- clk_i input 1: clock; all state updates on the rising edge.
- reset_ni input 1: reset, asynchronous, active-low.
- req_valid_i input [NUM_REQ-1:0]: producer i holds a result.
- req_data_i input [ROB_WB_WIDTH-1:0] x NUM_REQ: rob_wb_t payload per producer; its `cdb.valid` field is ignored.
- req_ready_o output [NUM_REQ-1:0]: producer i granted this cycle; the result is consumed at this edge.
- flush_i input 1: ROB mispredict (`rob_mispredict_o`).
- cdb_o output [ROB_WB_WIDTH-1:0] x NUM_LANES: registered rob_wb_t per lane.
- cdb_valid_o output [NUM_LANES-1:0]: lane k carries a result; equals `cdb_o[k].cdb.valid`.

## Operation
- State:
  - rr_ptr, $clog2(NUM_REQ) bits: highest-priority requester.
  - lane registers: NUM_LANES payloads and their valid bits.
- Grant selection (combinational):
  - Scan requesters in order rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - The first NUM_LANES with req_valid_i=1 receive req_ready_o=1.
  - The j-th grant in scan order, j=0..NUM_LANES-1, maps to lane j.
- Handshake:
  - req_ready_o may depend on req_valid_i.
  - A producer's req_valid_i must not depend on req_ready_o.
  - A producer holds valid and payload stable until granted.
  - An ungranted result is never dropped by the arbiter.
- Lane update at each edge:
  - A granted lane loads the requester payload, with `cdb.valid` forced to 1.
  - An ungranted lane loads all-zero (cdb_valid_o=0).
- Pointer update:
  - With at least one grant, rr_ptr = (index of last granted requester + 1) mod NUM_REQ.
  - With no grants, rr_ptr is unchanged.
  - Wrap-around uses explicit compare to NUM_REQ-1, since NUM_REQ need not be a power of two.
- flush_i=1:
  - req_ready_o is all 0.
  - All lanes clear at the next edge.
  - rr_ptr is unchanged.
  - Producers flush their own pending results.
- Simultaneous flush_i and requests: flush wins; no grants.
- Fewer valid requesters than lanes: the higher lanes are idle (zero).

## Timing
- Latency: grant at cycle t gives the result on cdb_o at cycle t+1.
- Throughput: NUM_LANES results per cycle.
- Reset values:
  - cdb_o all zero.
  - cdb_valid_o=0.
  - rr_ptr=0.
  - req_ready_o=0 while reset_ni=0, forced combinationally.
- Reset asserted mid-operation:
  - Outputs clear immediately, without waiting for a clock edge.
  - In-flight lane contents are lost.
  - The first post-reset grant starts from requester 0.
- Starvation bound: a continuously valid requester is granted within ceil(NUM_REQ/NUM_LANES) non-flush cycles.

## Structure
- The package already provides, and must keep holding:
  - rob_wb_t
  - ROB_WB_WIDTH
  - NUM_FU
- Add a package constant CDB_NUM_REQ, used as the default source for NUM_REQ.
- One sub-module, rr_select:
  - Combinational, parameterized NUM_REQ/NUM_LANES.
  - Inputs: valid vector and pointer.
  - Outputs: grant vector, per-lane requester index with lane-valid, and next pointer.
  - Reusable for reservation-station issue.
- The top level holds the lane registers, rr_ptr, and the flush/reset gating.

## Test plan
- Single requester:
  - Stimulus: NUM_LANES=2, only req 2 valid with rob_dest=5.
  - Cycle 0: req_ready_o=6'b000100.
  - Cycle 1: lane0 rob_dest=5 with valid=1; lane1 valid=0; rr_ptr=3.
- Full load:
  - Stimulus: all 6 requesters held valid, NUM_LANES=2, rr_ptr=0.
  - Grants per cycle: {0,1}, {2,3}, {4,5}, {0,1}; each requester served once every 3 cycles.
- Wrap-around:
  - Stimulus: rr_ptr=5, req 5 and req 0 valid.
  - lane0=req5, lane1=req0; rr_ptr becomes 1.
- Flush:
  - Stimulus: flush_i=1 with 4 valid requesters.
  - req_ready_o=0; next cycle cdb_valid_o=0; rr_ptr unchanged.
  - The following non-flush cycle grants from the old rr_ptr.
- Backpressure:
  - Stimulus: 3 valid requesters, NUM_LANES=2.
  - The ungranted one holds its payload and is granted next cycle.
  - Its lane payload is bit-identical to its input with valid=1.
- Async reset:
  - Stimulus: reset_ni low between clock edges while lanes are valid.
  - cdb_valid_o and req_ready_o go 0 immediately.
  - After release, the first grant goes to req 0.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the CDB writeback path: ROB writeback payload, sizing
// constants and a pointer-width helper used by the arbiter and its selector.
package cdb_arbiter_pkg;

   localparam int NUM_FU      = 2;
   localparam int CDB_NUM_REQ = 6;
   localparam int ROB_IDX_W   = 4;
   localparam int XLEN        = 32;

   typedef struct packed {
      logic                 valid;
      logic [ROB_IDX_W-1:0] rob_dest;
      logic [XLEN-1:0]      value;
   } cdb_t;

   typedef struct packed {
      cdb_t       cdb;
      logic       exception;
      logic [3:0] ex_cause;
   } rob_wb_t;

   localparam int ROB_WB_WIDTH = $bits(rob_wb_t);

   // A single requester still needs a one-bit pointer to keep ports legal.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-to-CDB bundle: per-producer request/payload/grant and the
// registered CDB lanes that feed the ROB and reservation stations.
//
// Handshake: a producer raises req_valid_i with its payload and holds both
// stable until req_ready_o is seen high; the result is consumed at that
// clock edge. req_ready_o may depend combinationally on req_valid_i, but a
// producer's req_valid_i must never depend on req_ready_o.
interface cdb_arbiter_if
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = CDB_NUM_REQ,
   parameter int NUM_LANES = NUM_FU
);
   logic    [NUM_REQ-1:0]   req_valid_i;
   rob_wb_t [NUM_REQ-1:0]   req_data_i;
   logic    [NUM_REQ-1:0]   req_ready_o;
   rob_wb_t [NUM_LANES-1:0] cdb_o;
   logic    [NUM_LANES-1:0] cdb_valid_o;

   modport master (
      output req_valid_i, req_data_i,
      input  req_ready_o, cdb_o, cdb_valid_o
   );

   modport slave (
      input  req_valid_i, req_data_i,
      output req_ready_o, cdb_o, cdb_valid_o
   );
endinterface

// File: rtl/cdb_arbiter_rr_select.sv
// Multi-grant round-robin selector: walks the requesters starting at ptr and
// hands out up to NUM_LANES grants in scan order. Purely combinational so it
// can be reused for reservation-station issue selection.
module rr_select
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = CDB_NUM_REQ,
   parameter int NUM_LANES = NUM_FU,
   localparam int PTR_W    = ptr_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]              valid,
   input  logic [PTR_W-1:0]                ptr,
   output logic [NUM_REQ-1:0]              grant,
   output logic [NUM_LANES-1:0][PTR_W-1:0] lane_idx,
   output logic [NUM_LANES-1:0]            lane_valid,
   output logic [PTR_W-1:0]                next_ptr
);

   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

   // Scan ptr, ptr+1, ... with explicit wrap since NUM_REQ may not be a power of two.
   always_comb begin
      logic [PTR_W-1:0] idx;
      int               cnt;
      grant      = '0;
      lane_idx   = '0;
      lane_valid = '0;
      next_ptr   = ptr;
      idx        = ptr;
      cnt        = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (valid[idx] && (cnt < NUM_LANES)) begin
            grant[idx] = 1'b1;
            for (int k = 0; k < NUM_LANES; k++) begin
               if (k == cnt) begin
                  lane_idx[k]   = idx;
                  lane_valid[k] = 1'b1;
               end
            end
            cnt      = cnt + 1;
            next_ptr = (idx == LAST_IDX) ? '0 : idx + 1'b1;
         end
         idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB writeback arbiter: grants up to NUM_LANES producer results per cycle in
// round-robin order and registers them onto the common data bus. A ROB
// mispredict suppresses all grants and clears the lanes at the next edge.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = CDB_NUM_REQ,
   parameter int NUM_LANES = NUM_FU,
   localparam int PTR_W    = ptr_width(NUM_REQ)
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             flush_i,
   cdb_arbiter_if.slave     bus,
   output logic [PTR_W-1:0] rr_ptr_o
);

   logic [PTR_W-1:0]                rr_ptr_q;
   logic [PTR_W-1:0]                next_ptr;
   logic [NUM_REQ-1:0]              req_eligible;
   logic [NUM_REQ-1:0]              grant;
   logic [NUM_LANES-1:0][PTR_W-1:0] lane_idx;
   logic [NUM_LANES-1:0]            lane_valid;
   rob_wb_t [NUM_LANES-1:0]         lane_next;
   rob_wb_t [NUM_LANES-1:0]         lane_q;

   // Masking requests on flush means no grants, idle lanes and an unchanged pointer.
   assign req_eligible = flush_i ? '0 : bus.req_valid_i;

   rr_select #(
      .NUM_REQ   (NUM_REQ),
      .NUM_LANES (NUM_LANES)
   ) u_rr_select (
      .valid      (req_eligible),
      .ptr        (rr_ptr_q),
      .grant      (grant),
      .lane_idx   (lane_idx),
      .lane_valid (lane_valid),
      .next_ptr   (next_ptr)
   );

   // Grants are gated by reset so no producer retires a result while held in reset.
   assign bus.req_ready_o = reset_ni ? grant : '0;

   // Route each granted payload to its lane with the CDB valid bit forced on.
   always_comb begin
      lane_next = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         if (lane_valid[k]) begin
            lane_next[k]           = bus.req_data_i[lane_idx[k]];
            lane_next[k].cdb.valid = 1'b1;
         end
      end
   end

   // Lane registers and round-robin pointer; reset clears them without a clock.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         rr_ptr_q <= '0;
         lane_q   <= '0;
      end else begin
         rr_ptr_q <= next_ptr;
         lane_q   <= lane_next;
      end
   end

   // Lane valid bits mirror the payload's own CDB valid field.
   always_comb begin
      bus.cdb_valid_o = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         bus.cdb_valid_o[k] = lane_q[k].cdb.valid;
      end
   end

   assign bus.cdb_o = lane_q;
   assign rr_ptr_o  = rr_ptr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomised and directed bench for cdb_arbiter with a queue-based scoreboard.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int NR = 6;
   localparam int NL = 2;
   localparam int PW = 3;
   localparam int LW = NL * ROB_WB_WIDTH;

   logic          clk      = 1'b0;
   logic          reset_ni = 1'b0;
   logic          flush_i  = 1'b0;
   logic [PW-1:0] rr_ptr;

   cdb_arbiter_if #(.NUM_REQ(NR), .NUM_LANES(NL)) bus ();

   cdb_arbiter #(.NUM_REQ(NR), .NUM_LANES(NL)) dut (
      .clk_i    (clk),
      .reset_ni (reset_ni),
      .flush_i  (flush_i),
      .bus      (bus.slave),
      .rr_ptr_o (rr_ptr)
   );

   // clock / reset
   always #10 clk = ~clk;

   // producer state and reference model
   logic    pend_v [NR];
   rob_wb_t pend_d [NR];
   int      model_ptr  = 0;
   bit      refill_all = 1'b0;
   int      arrive_pct = 0;
   logic [NR-1:0] seen_ready;

   // scoreboard
   logic [LW-1:0] exp_q [$];
   logic [NL-1:0] expv_q [$];
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic rob_wb_t rand_payload();
      rob_wb_t p;
      p = rob_wb_t'(ROB_WB_WIDTH'({$urandom, $urandom}));
      return p;
   endfunction

   task automatic clear_pend();
      for (int i = 0; i < NR; i++) begin
         pend_v[i] = 1'b0;
         pend_d[i] = rand_payload();
      end
   endtask

   // reset asserted mid-cycle, optionally checking outputs drop without a clock
   task automatic do_reset(input bit check_now);
      @(posedge clk);
      #5;
      reset_ni = 1'b0;
      if (check_now) begin
         #1;
         check("async_rst_cdb_valid", 128'(bus.cdb_valid_o), 128'(0));
         check("async_rst_req_ready", 128'(bus.req_ready_o), 128'(0));
         check("async_rst_cdb", 128'(bus.cdb_o), 128'(0));
      end
      exp_q.delete();
      expv_q.delete();
      model_ptr       = 0;
      refill_all      = 1'b0;
      arrive_pct      = 0;
      flush_i         = 1'b0;
      bus.req_valid_i = '0;
      clear_pend();
      repeat (2) @(posedge clk);
      #5;
      reset_ni = 1'b1;
   endtask

   // one cycle: drive producers, check grants against the model, queue expected lanes
   task automatic step(input bit f);
      int granted [$];
      logic [NR-1:0] exp_ready;
      rob_wb_t [NL-1:0] lanes;
      logic [NL-1:0] lv;
      int r;
      @(posedge clk);
      #1;
      flush_i = f;
      for (int i = 0; i < NR; i++) begin
         bus.req_valid_i[i] = pend_v[i];
         bus.req_data_i[i]  = pend_d[i];
      end
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
         r = (model_ptr + i) % NR;
         if (!f && pend_v[r] && granted.size() < NL) granted.push_back(r);
      end
      exp_ready = '0;
      lanes     = '0;
      lv        = '0;
      foreach (granted[j]) begin
         exp_ready[granted[j]] = 1'b1;
         lanes[j]              = pend_d[granted[j]];
         lanes[j].cdb.valid    = 1'b1;
         lv[j]                 = 1'b1;
      end
      check("req_ready", 128'(bus.req_ready_o), 128'(exp_ready));
      check("rr_ptr", 128'(rr_ptr), 128'(model_ptr));
      seen_ready = bus.req_ready_o;
      exp_q.push_back(lanes);
      expv_q.push_back(lv);
      if (granted.size() > 0) model_ptr = (granted[granted.size()-1] + 1) % NR;
      foreach (granted[j]) pend_v[granted[j]] = 1'b0;
      if (f) for (int i = 0; i < NR; i++) pend_v[i] = 1'b0;
      for (int i = 0; i < NR; i++) begin
         if (!pend_v[i] && (refill_all || ($urandom_range(99) < arrive_pct))) begin
            pend_v[i] = 1'b1;
            pend_d[i] = rand_payload();
         end
      end
   endtask

   // monitor: compare registered lanes after each edge against the queued expectation
   initial begin
      logic [LW-1:0] e;
      logic [NL-1:0] ev;
      forever begin
         @(posedge clk);
         #3;
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            ev = expv_q.pop_front();
            check("cdb_lanes", 128'(bus.cdb_o), 128'(e));
            check("cdb_valid", 128'(bus.cdb_valid_o), 128'(ev));
         end
      end
   end

   // driver / directed sequence
   initial begin
      logic [PW-1:0] ptr_before;
      logic [NR-1:0] full_exp [4];
      full_exp[0] = 6'b000011;
      full_exp[1] = 6'b001100;
      full_exp[2] = 6'b110000;
      full_exp[3] = 6'b000011;
      bus.req_valid_i = '0;
      bus.req_data_i  = '0;
      clear_pend();
      repeat (2) @(posedge clk);
      #5;
      check("rst_req_ready", 128'(bus.req_ready_o), 128'(0));
      check("rst_cdb_valid", 128'(bus.cdb_valid_o), 128'(0));
      check("rst_cdb", 128'(bus.cdb_o), 128'(0));
      check("rst_rr_ptr", 128'(rr_ptr), 128'(0));
      reset_ni = 1'b1;

      // single requester
      pend_v[2] = 1'b1;
      pend_d[2] = rand_payload();
      pend_d[2].cdb.rob_dest = 4'd5;
      step(1'b0);
      check("single_ready", 128'(seen_ready), 128'(6'b000100));
      step(1'b0);
      check("single_lane0_dest", 128'(bus.cdb_o[0].cdb.rob_dest), 128'(5));
      check("single_lane_valid", 128'(bus.cdb_valid_o), 128'(2'b01));
      check("single_ptr", 128'(rr_ptr), 128'(3));

      // backpressure
      do_reset(1'b0);
      for (int i = 0; i < 3; i++) pend_v[i] = 1'b1;
      step(1'b0);
      check("bp_ready0", 128'(seen_ready), 128'(6'b000011));
      step(1'b0);
      check("bp_ready1", 128'(seen_ready), 128'(6'b000100));
      step(1'b0);

      // full load
      do_reset(1'b0);
      refill_all = 1'b1;
      for (int i = 0; i < NR; i++) pend_v[i] = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step(1'b0);
         check("full_ready", 128'(seen_ready), 128'(full_exp[c]));
      end

      // wrap-around
      do_reset(1'b0);
      pend_v[4] = 1'b1;
      step(1'b0);
      pend_v[5] = 1'b1;
      pend_v[0] = 1'b1;
      step(1'b0);
      check("wrap_ready", 128'(seen_ready), 128'(6'b100001));
      step(1'b0);
      check("wrap_ptr", 128'(rr_ptr), 128'(1));

      // flush with four requesters pending
      pend_v[0] = 1'b1; pend_v[2] = 1'b1; pend_v[3] = 1'b1; pend_v[4] = 1'b1;
      ptr_before = rr_ptr;
      step(1'b1);
      check("flush_ready", 128'(seen_ready), 128'(0));
      pend_v[0] = 1'b1; pend_v[2] = 1'b1; pend_v[3] = 1'b1; pend_v[4] = 1'b1;
      step(1'b0);
      check("flush_cdb_valid", 128'(bus.cdb_valid_o), 128'(0));
      check("flush_ptr_kept", 128'(rr_ptr), 128'(ptr_before));
      check("post_flush_ready", 128'(seen_ready), 128'(6'b001100));
      step(1'b0);

      // async reset while lanes are busy
      refill_all = 1'b1;
      for (int i = 0; i < NR; i++) pend_v[i] = 1'b1;
      step(1'b0);
      step(1'b0);
      do_reset(1'b1);
      for (int i = 0; i < NR; i++) pend_v[i] = 1'b1;
      step(1'b0);
      check("post_rst_ready", 128'(seen_ready), 128'(6'b000011));
      step(1'b0);

      // randomised traffic with occasional flushes
      refill_all = 1'b0;
      arrive_pct = 45;
      for (int c = 0; c < 3000; c++) begin
         step($urandom_range(99) < 5);
      end
      arrive_pct = 0;
      @(posedge clk);
      #5;
      check("scoreboard_drained", 128'(exp_q.size()), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
